// File: rtl/pipeline_result_pkg.sv
// ==========================================================================
// pipeline_result_pkg: types shared by the (a+b)*c pipeline and its result buffer
// Rev 1.0
// ==========================================================================
`default_nettype none

package pipeline_result_pkg;

   localparam int RESULT_W = 16;

   typedef logic [RESULT_W-1:0] result_t;

   typedef struct packed {
      logic [31:0] accepted;
      logic [15:0] dropped;
      result_t     max;
   } result_stats_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/result_fifo_mem.sv
// ==========================================================================
// result_fifo_mem: DEPTH x DATA_W storage, synchronous write, asynchronous read
// Rev 1.0
// ==========================================================================
`default_nettype none

module result_fifo_mem #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 8,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/pipeline_result_buffer.sv
// ==========================================================================
// pipeline_result_buffer: result FIFO with skid-reserving back-pressure.
// Optional statistics outputs: PIPELINE_RESULT_STATS_EN.   Rev 1.0
// ==========================================================================
`default_nettype none

module pipeline_result_buffer
   import pipeline_result_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 8,
   parameter int SKID   = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       flush,
   input  logic                       in_valid,
   input  logic [DATA_W-1:0]          in_data,
   output logic                       pipe_enable,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          out_data,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow
`ifdef PIPELINE_RESULT_STATS_EN
   ,
   output logic [31:0]                stat_accepted,
   output logic [15:0]                stat_dropped,
   output logic [DATA_W-1:0]          stat_max
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] EN_MAX   = CW'(DEPTH - SKID);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          full;
   logic          push;
   logic          pop;
   logic          drop;
   logic          wr_en;

   assign full      = (count == FULL_CNT);
   assign out_valid = (count != '0);
   assign pop       = out_valid && out_ready;
   // A pop frees the slot this edge, so a full FIFO still accepts a write.
   assign push      = in_valid && (!full || pop);
   assign drop      = in_valid && !push;
   assign wr_en     = push && reset_n && !flush;

   assign pipe_enable = reset_n && (count <= EN_MAX);

   result_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_data (in_data),
      .rd_addr (rd_ptr),
      .rd_data (out_data)
   );

   always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
         if (drop) overflow <= 1'b1;
      end
   end

`ifdef PIPELINE_RESULT_STATS_EN
   always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
         stat_accepted <= '0;
         stat_dropped  <= '0;
         stat_max      <= '0;
      end else begin
         if (push) begin
            stat_accepted <= stat_accepted + 32'd1;
            if (in_data > stat_max) stat_max <= in_data;
         end
         if (drop) stat_dropped <= sat_inc16(stat_dropped);
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_result_buffer.sv
// ==========================================================================
// tb_pipeline_result_buffer: directed + random checks against a queue model
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_pipeline_result_buffer;

   localparam int DATA_W = 16;
   localparam int DEPTH  = 8;
   localparam int SKID   = 4;
   localparam int CW     = $clog2(DEPTH+1);

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              flush = 1'b0;
   logic              in_valid = 1'b0;
   logic [DATA_W-1:0] in_data = '0;
   logic              pipe_enable;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] out_data;
   logic [CW-1:0]     count;
   logic              overflow;
`ifdef PIPELINE_RESULT_STATS_EN
   logic [31:0]       stat_accepted;
   logic [15:0]       stat_dropped;
   logic [DATA_W-1:0] stat_max;
`endif

   int total = 0;
   int bad   = 0;

   int q[$];
   bit m_ovf = 1'b0;
   int m_acc = 0;
   int m_drop = 0;
   int m_max = 0;

   always #5 clk = ~clk;

   pipeline_result_buffer #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .SKID   (SKID)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .pipe_enable (pipe_enable),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .count       (count),
      .overflow    (overflow)
`ifdef PIPELINE_RESULT_STATS_EN
      ,
      .stat_accepted (stat_accepted),
      .stat_dropped  (stat_dropped),
      .stat_max      (stat_max)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of inputs, check current outputs, then advance the model.
   task automatic step(input logic v, input logic [15:0] d, input logic r,
                       input logic f, input logic rn);
      bit popb, pushb;
      in_valid = v; in_data = d; out_ready = r; flush = f; reset_n = rn;
      #1;
      if (!rn) begin
         chk("pe_in_reset", 32'(pipe_enable), 32'd0);
      end else begin
         chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
         chk("count", 32'(count), 32'(q.size()));
         chk("overflow", 32'(overflow), 32'(m_ovf));
         chk("pipe_enable", 32'(pipe_enable), 32'((DEPTH - q.size()) >= SKID));
         if (q.size() != 0) chk("out_data", 32'(out_data), 32'(q[0]));
`ifdef PIPELINE_RESULT_STATS_EN
         chk("stat_accepted", stat_accepted, 32'(m_acc));
         chk("stat_dropped", 32'(stat_dropped), 32'(m_drop));
         chk("stat_max", 32'(stat_max), 32'(m_max));
`endif
      end
      if (!rn || f) begin
         q.delete(); m_ovf = 0; m_acc = 0; m_drop = 0; m_max = 0;
      end else begin
         popb  = (q.size() != 0) && r;
         pushb = v && (q.size() < DEPTH || popb);
         if (popb) void'(q.pop_front());
         if (pushb) begin
            q.push_back(int'(d));
            m_acc++;
            if (int'(d) > m_max) m_max = int'(d);
         end
         if (v && !pushb) begin
            m_ovf = 1;
            if (m_drop < 16'hFFFF) m_drop++;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int vals[10] = '{16, 48, 30, 60, 78, 5, 9, 11, 90, 99};
      int vbias, rbias;
      @(negedge clk);

      // Reset
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      chk("rst_pe_after", 32'(pipe_enable), 32'd1);

      // Streaming pass-through
      for (int i = 0; i < 5; i++) step(1, 16'(vals[i]), 1, 0, 1);
      step(0, 0, 1, 0, 1);
      step(0, 0, 1, 0, 1);

      // Fill to the skid threshold
      for (int i = 0; i < 4; i++) step(1, 16'(100 + i), 0, 0, 1);
      chk("tp2_pe_at4", 32'(pipe_enable), 32'd1);
      step(1, 16'd104, 0, 0, 1);
      chk("tp2_count5", 32'(count), 32'd5);
      chk("tp2_pe_at5", 32'(pipe_enable), 32'd0);
      step(0, 0, 0, 1, 1);

      // Overfill by two, then drain
      for (int i = 0; i < 10; i++) step(1, 16'(vals[i]), 0, 0, 1);
      chk("tp3_count8", 32'(count), 32'd8);
      chk("tp3_ovf", 32'(overflow), 32'd1);
`ifdef PIPELINE_RESULT_STATS_EN
      chk("tp3_acc", stat_accepted, 32'd8);
      chk("tp3_drop", 32'(stat_dropped), 32'd2);
      chk("tp3_max", 32'(stat_max), 32'd78);
`endif
      for (int i = 0; i < 9; i++) step(0, 0, 1, 0, 1);
      step(0, 0, 0, 1, 1);

      // Full with simultaneous push and pop
      for (int i = 0; i < 8; i++) step(1, 16'(200 + i), 0, 0, 1);
      step(1, 16'd300, 1, 0, 1);
      chk("tp4_count8", 32'(count), 32'd8);
      chk("tp4_ovf", 32'(overflow), 32'd0);
      for (int i = 0; i < 9; i++) step(0, 0, 1, 0, 1);

      // Flush beats a same-cycle push
      for (int i = 0; i < 3; i++) step(1, 16'(400 + i), 0, 0, 1);
      step(1, 16'd999, 0, 1, 1);
      chk("flush_count", 32'(count), 32'd0);
      chk("flush_valid", 32'(out_valid), 32'd0);
      chk("flush_ovf", 32'(overflow), 32'd0);
      chk("flush_pe", 32'(pipe_enable), 32'd1);

      // Random traffic in phases of varying producer/consumer bias
      for (int p = 0; p < 8; p++) begin
         vbias = int'($urandom_range(1, 9));
         rbias = int'($urandom_range(1, 9));
         for (int i = 0; i < 80; i++) begin
            step($urandom_range(0, 9) < vbias, 16'($urandom),
                 $urandom_range(0, 9) < rbias,
                 $urandom_range(0, 59) == 0,
                 $urandom_range(0, 119) != 0);
         end
      end
      step(0, 0, 1, 0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
